// File: rtl/mux_nx1_arb_pkg.sv
// Shared constants and helpers for the N:1 arbitrated mux.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_nx1_arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_arb_grant.sv
// Rotating first-set search: one-hot grant to the first request at or above ptr.
// Latency: purely combinational.
// Backpressure: none here; the caller qualifies the grant with its load condition.
module mux_arb_grant
    import mux_nx1_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx,
    output logic          any
);

    // Walk the request vector from ptr upward, wrapping N-1 -> 0; first hit wins.
    always_comb begin : p_search
        logic [SW-1:0] w_idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = SW'((int'(ptr) + k) % N);
            if (!any && req[w_idx]) begin
                any          = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_arb.sv
// N:1 arbitrated mux with a single registered output stage (fixed priority or round robin).
// Latency: one cycle from input transfer edge to out_valid; one word per cycle at full rate.
// Backpressure: output register reloads only when empty or out_ready; in_ready is load AND grant.
module mux_nx1_arb
    import mux_nx1_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = MODE_RR,
    localparam int SW   = (N > 1) ? clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_sel,
    input  logic               out_ready,
    output logic [15:0]        xfer_cnt
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_sel;
    logic [15:0]      r_xfer_cnt;

    logic             w_load;
    logic             w_xfer;
    logic [SW-1:0]    w_ptr;
    logic [N-1:0]     w_gnt;
    logic [SW-1:0]    w_gnt_idx;
    logic             w_any;
    logic [WIDTH-1:0] w_sel_data;

    // Register is free when empty or being drained this cycle. Reset is folded in
    // so that no channel sees a ready while the block is held in reset.
    assign w_load   = (!r_out_valid || out_ready) && rst_n;
    assign w_xfer   = w_load && w_any;
    assign in_ready = w_load ? w_gnt : '0;

    mux_arb_grant #(
        .N  (N),
        .SW (SW)
    ) u_grant (
        .req       (in_valid),
        .ptr       (w_ptr),
        .grant     (w_gnt),
        .grant_idx (w_gnt_idx),
        .any       (w_any)
    );

    // AND-OR select of the granted channel; grant is one-hot so at most one term contributes.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            w_sel_data = w_sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
        end
    end

    // Search start pointer: advances past the last winner in round-robin mode, else pinned to 0.
    generate
        if (MODE == MODE_RR && N > 1) begin : g_rr_ptr
            logic [SW-1:0] r_ptr;

            // Rotate past the channel that just transferred; hold otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= '0;
                end else if (w_xfer) begin
                    r_ptr <= (w_gnt_idx == SW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
                end
            end

            assign w_ptr = r_ptr;
        end else begin : g_fixed_ptr
            assign w_ptr = '0;
        end
    endgenerate

    // Output stage: capture the granted word on load, drop valid when nothing is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_gnt_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Free-running count of accepted input transfers, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_xfer) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Directed bench for mux_nx1_arb: round-robin, fixed-priority and single-channel instances.
// Latency: checks outputs #1 after each rising edge, combinational ready before the edge.
// Backpressure: exercised by holding out_ready low with a full output register.
module tb_mux_nx1_arb;

    logic         clk;
    logic         rst_n;

    // Round-robin instance (N=4, MODE=1)
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready;
    logic [15:0]  xfer_cnt;

    // Fixed-priority instance (N=4, MODE=0), shares in_data
    logic [3:0]   f_valid;
    logic [3:0]   f_ready;
    logic         f_ovalid;
    logic [31:0]  f_odata;
    logic [1:0]   f_osel;
    logic         f_oready;
    logic [15:0]  f_cnt;

    // Single-channel instance (N=1)
    logic [0:0]   s_valid;
    logic [31:0]  s_data;
    logic [0:0]   s_ready;
    logic         s_ovalid;
    logic [31:0]  s_odata;
    logic [0:0]   s_osel;
    logic         s_oready;
    logic [15:0]  s_cnt;

    int checks;
    int failures;
    logic [15:0] exp_cnt;

    mux_nx1_arb #(.WIDTH(32), .N(4), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
    );

    mux_nx1_arb #(.WIDTH(32), .N(4), .MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .in_valid(f_valid), .in_data(in_data),
        .in_ready(f_ready), .out_valid(f_ovalid), .out_data(f_odata),
        .out_sel(f_osel), .out_ready(f_oready), .xfer_cnt(f_cnt)
    );

    mux_nx1_arb #(.WIDTH(32), .N(1), .MODE(1)) u_one (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_data(s_data),
        .in_ready(s_ready), .out_valid(s_ovalid), .out_data(s_odata),
        .out_sel(s_osel), .out_ready(s_oready), .xfer_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ovld;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // RR fairness, then backpressure on a held word, then idle drain.
        vecs[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[5] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[6] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[7] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[8] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[9] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};

        checks   = 0;
        failures = 0;
        exp_cnt  = 16'd0;

        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + i;
        f_valid   = 4'b0000;
        f_oready  = 1'b1;
        s_valid   = 1'b0;
        s_data    = 32'h0;
        s_oready  = 1'b1;

        // Reset state, with requests already pending.
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_out_sel",   {30'd0, out_sel}, 32'd0);
        chk("rst_xfer_cnt",  {16'd0, xfer_cnt}, 32'd0);
        chk("rst_in_ready",  {28'd0, in_ready}, 32'd0);
        rst_n = 1'b1;

        // Table-driven sequence on the round-robin instance.
        for (int v = 0; v < 10; v++) begin
            in_valid  = vecs[v].vld;
            out_ready = vecs[v].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", v), {28'd0, in_ready}, {28'd0, vecs[v].exp_rdy});
            if (vecs[v].exp_rdy != 4'b0000) exp_cnt = exp_cnt + 16'd1;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", v), {31'd0, out_valid}, {31'd0, vecs[v].exp_ovld});
            chk($sformatf("vec%0d_out_sel", v), {30'd0, out_sel}, {30'd0, vecs[v].exp_sel});
            chk($sformatf("vec%0d_out_data", v), out_data, 32'hA0 + {30'd0, vecs[v].exp_sel});
            if (v == 4) chk("rr_xfer_cnt_5", {16'd0, xfer_cnt}, 32'd5);
        end
        chk("table_xfer_cnt", {16'd0, xfer_cnt}, {16'd0, exp_cnt});

        // Backpressure on a DEADBEEF word from channel 2 (ptr now 2), then wrap 3 -> 0.
        in_data[2*32 +: 32] = 32'hDEADBEEF;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        chk("bp_load_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_load_data",  out_data, 32'hDEADBEEF);
        in_valid = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d_in_ready", c), {28'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d_data", c), out_data, 32'hDEADBEEF);
            chk($sformatf("bp%0d_sel", c), {30'd0, out_sel}, 32'd2);
            chk($sformatf("bp%0d_valid", c), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("wrap_gnt3_ready", {28'd0, in_ready}, 32'b1000);
        chk("bp_release_data_held", out_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        chk("wrap_sel3", {30'd0, out_sel}, 32'd3);
        chk("wrap_data3", out_data, 32'hA3);
        chk("wrap_gnt0_ready", {28'd0, in_ready}, 32'b0001);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        chk("wrap_sel0", {30'd0, out_sel}, 32'd0);
        chk("wrap_data0", out_data, 32'hA0);

        // Fixed priority on u_fix and register-slice behaviour on u_one; RR instance idle.
        in_valid = 4'b0000;
        f_valid  = 4'b1010;
        s_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_oready = (k != 2);
            s_data   = 32'h55 + k;
            #1;
            chk($sformatf("fix%0d_in_ready", k), {28'd0, f_ready}, 32'b0010);
            chk($sformatf("one%0d_in_ready", k), {31'd0, s_ready}, (k == 2) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
            chk($sformatf("fix%0d_sel", k), {30'd0, f_osel}, 32'd1);
            chk($sformatf("fix%0d_data", k), f_odata, 32'hA1);
            chk($sformatf("one%0d_data", k), s_odata, (k == 2) ? 32'h56 : 32'h55 + k);
            chk($sformatf("one%0d_sel", k), {31'd0, s_osel}, 32'd0);
            chk($sformatf("one%0d_valid", k), {31'd0, s_ovalid}, 32'd1);
        end
        chk("rr_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("rr_idle_data_hold", out_data, 32'hA0);
        chk("fix_cnt", {16'd0, f_cnt}, 32'd4);
        f_valid = 4'b0000;
        s_valid = 1'b0;

        // Counter wrap: run transfers until the model count reaches 0xFFFF, then one more.
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        #1;
        while (exp_cnt != 16'hFFFF) begin
            @(posedge clk);
            exp_cnt = exp_cnt + 16'd1;
        end
        #1;
        chk("cnt_ffff", {16'd0, xfer_cnt}, 32'h0000FFFF);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        chk("cnt_wrap_0", {16'd0, xfer_cnt}, {16'd0, exp_cnt});

        // Asynchronous reset mid-transfer with a word held in the output register.
        in_valid = 4'b1111;
        @(posedge clk); #1;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data",  out_data, 32'd0);
        chk("arst_out_sel",   {30'd0, out_sel}, 32'd0);
        chk("arst_xfer_cnt",  {16'd0, xfer_cnt}, 32'd0);
        chk("arst_in_ready",  {28'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_first_grant", {28'd0, in_ready}, 32'b0001);
        @(posedge clk); #1;
        chk("post_rst_sel", {30'd0, out_sel}, 32'd0);
        chk("post_rst_cnt", {16'd0, xfer_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
